// File: rtl/bsg_piso_pkg.sv
// Shared types for the parallel-in/serial-out width converter.
//   bsg_piso_state_e : controller states (INIT after reset, IDLE accepting, XMIT draining)
package bsg_piso_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    XMIT = 2'd2
  } bsg_piso_state_e;

endpackage

// File: rtl/bsg_parallel_in_serial_out_arst_if.sv
// Handshake bundle for the parallel-in/serial-out converter.
//   valid_i/data_i/ready_and_o : wide upstream ready/valid channel
//   valid_o/data_o/ready_and_i : narrow downstream ready/valid channel
//   slave  : converter side
//   master : environment side (upstream producer + downstream consumer)
interface bsg_parallel_in_serial_out_arst_if #(
  parameter int unsigned width_p = 4,
  parameter int unsigned els_p   = 4
);

  logic                       valid_i;
  logic [els_p*width_p-1:0]   data_i;
  logic                       ready_and_o;
  logic                       valid_o;
  logic [width_p-1:0]         data_o;
  logic                       ready_and_i;

  modport slave (
    input  valid_i,
    input  data_i,
    input  ready_and_i,
    output ready_and_o,
    output valid_o,
    output data_o
  );

  modport master (
    output valid_i,
    output data_i,
    output ready_and_i,
    input  ready_and_o,
    input  valid_o,
    input  data_o
  );

endinterface

// File: rtl/bsg_piso_index_counter.sv
// Word-index up-counter with synchronous clear and enable.
//   clk_i     : clock
//   reset_n_i : asynchronous active-low reset (count -> 0)
//   clear_i   : synchronous clear, wins over en_i
//   en_i      : increment; rolls to 0 past max_val_p
//   count_o   : current index
module bsg_piso_index_counter #(
  parameter  int unsigned max_val_p = 3,
  localparam int unsigned cnt_w_lp  = (max_val_p < 2) ? 1 : $clog2(max_val_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                clear_i,
  input  logic                en_i,
  output logic [cnt_w_lp-1:0] count_o
);

  localparam logic [cnt_w_lp-1:0] max_lp = cnt_w_lp'(max_val_p);

  logic [cnt_w_lp-1:0] count_r;

  // Index register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_r <= '0;
    end else if (clear_i) begin
      count_r <= '0;
    end else if (en_i) begin
      count_r <= (count_r == max_lp) ? '0 : count_r + cnt_w_lp'(1);
    end
  end

  assign count_o = count_r;

  // Index must never reach els_p; compared at 32 bits so the check stays meaningful at any width
  a_index_in_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    32'(count_r) <= 32'(max_val_p));

endmodule

// File: rtl/bsg_parallel_in_serial_out_arst.sv
// Parallel-in/serial-out width converter: takes one els_p*width_p word and
// emits els_p width_p words, least-significant word first.
//   clk_i     : clock
//   reset_n_i : asynchronous active-low reset
//   link      : slave side of the handshake bundle (wide in, narrow out)
// ready_and_o/valid_o are flops loaded from the next-state decode; data_o is
// a select of the data register by the index register, so no input reaches
// an output combinationally.
module bsg_parallel_in_serial_out_arst
  import bsg_piso_pkg::*;
#(
  parameter  int unsigned width_p   = 4,
  parameter  int unsigned els_p     = 4,
  localparam int unsigned lg_els_lp = (els_p < 2) ? 1 : $clog2(els_p)
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  bsg_parallel_in_serial_out_arst_if.slave     link
);

  localparam logic [lg_els_lp-1:0] last_idx_lp = lg_els_lp'(els_p - 1);

  bsg_piso_state_e                  state_r;
  bsg_piso_state_e                  state_n;
  logic [els_p-1:0][width_p-1:0]    data_r;
  logic [lg_els_lp-1:0]             idx;
  logic                             load;
  logic                             cnt_clr;
  logic                             cnt_en;
  logic                             ready_n;
  logic                             valid_n;
  logic                             ready_r;
  logic                             valid_r;

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= INIT;
    end else begin
      state_r <= state_n;
    end
  end

  // Next state, datapath controls and next output flags
  always_comb begin
    state_n = state_r;
    load    = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_r)
      INIT: begin
        state_n = IDLE;
      end
      IDLE: begin
        if (link.valid_i) begin
          load    = 1'b1;
          cnt_clr = 1'b1;
          state_n = XMIT;
        end
      end
      XMIT: begin
        if (link.ready_and_i) begin
          if (idx == last_idx_lp) begin
            cnt_clr = 1'b1;
            state_n = IDLE;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      default: begin
        state_n = INIT;
      end
    endcase
    ready_n = (state_n == IDLE);
    valid_n = (state_n == XMIT);
  end

  // Handshake output flags
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ready_r <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      ready_r <= ready_n;
      valid_r <= valid_n;
    end
  end

  // Wide data register; left untouched on return to IDLE
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_r <= '0;
    end else if (load) begin
      data_r <= link.data_i;
    end
  end

  bsg_piso_index_counter #(
    .max_val_p (els_p - 1)
  ) u_index (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (cnt_clr),
    .en_i      (cnt_en),
    .count_o   (idx)
  );

  assign link.ready_and_o = ready_r;
  assign link.valid_o     = valid_r;

  // Word select; a single-word configuration needs no index
  if (els_p == 1) begin : g_one_word
    assign link.data_o = data_r[0];
  end else begin : g_many_words
    assign link.data_o = data_r[idx];
  end

endmodule

// File: tb/tb_bsg_parallel_in_serial_out_arst.sv
// Bench for bsg_parallel_in_serial_out_arst: a queue-based reference model
// per instance (els_p=4/width_p=4 and els_p=1/width_p=8) checked every cycle,
// plus directed sequences with literal expectations.
module tb_bsg_parallel_in_serial_out_arst;

  logic clk_i     = 1'b0;
  logic reset_n_i = 1'b0;
  bit   run       = 1'b1;
  int   n_chk     = 0;
  int   n_pass    = 0;

  always #5 clk_i = ~clk_i;

  bsg_parallel_in_serial_out_arst_if #(.width_p(4), .els_p(4)) bus_a ();
  bsg_parallel_in_serial_out_arst_if #(.width_p(8), .els_p(1)) bus_b ();

  bsg_parallel_in_serial_out_arst #(.width_p(4), .els_p(4)) dut_a (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .link      (bus_a)
  );

  bsg_parallel_in_serial_out_arst #(.width_p(8), .els_p(1)) dut_b (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .link      (bus_b)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: after reset one "not ready" cycle, then an accepted wide
  // word becomes a queue of narrow words popped one per downstream accept.
  logic [3:0] q_a[$];
  logic [7:0] q_b[$];
  bit         init_a = 1'b1;
  bit         init_b = 1'b1;

  always @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      q_a.delete();
      init_a = 1'b1;
    end else if (init_a) begin
      init_a = 1'b0;
    end else if (q_a.size() == 0) begin
      if (bus_a.valid_i)
        for (int k = 0; k < 4; k++) q_a.push_back(bus_a.data_i[k*4 +: 4]);
    end else if (bus_a.ready_and_i) begin
      void'(q_a.pop_front());
    end
  end

  always @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      q_b.delete();
      init_b = 1'b1;
    end else if (init_b) begin
      init_b = 1'b0;
    end else if (q_b.size() == 0) begin
      if (bus_b.valid_i) q_b.push_back(bus_b.data_i);
    end else if (bus_b.ready_and_i) begin
      void'(q_b.pop_front());
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk_i) begin
    if (run) begin
      check("a_ready", 32'(bus_a.ready_and_o), 32'(!init_a && q_a.size() == 0));
      check("a_valid", 32'(bus_a.valid_o), 32'(q_a.size() != 0));
      if (q_a.size() != 0) check("a_data", 32'(bus_a.data_o), 32'(q_a[0]));
      check("b_ready", 32'(bus_b.ready_and_o), 32'(!init_b && q_b.size() == 0));
      check("b_valid", 32'(bus_b.valid_o), 32'(q_b.size() != 0));
      if (q_b.size() != 0) check("b_data", 32'(bus_b.data_o), 32'(q_b[0]));
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_a(input string nm, input logic ev, input logic [3:0] ed);
    check({nm, "_v"}, 32'(bus_a.valid_o), 32'(ev));
    if (ev) check({nm, "_d"}, 32'(bus_a.data_o), 32'(ed));
  endtask

  task automatic expect_b(input string nm, input logic ev, input logic [7:0] ed);
    check({nm, "_v"}, 32'(bus_b.valid_o), 32'(ev));
    if (ev) check({nm, "_d"}, 32'(bus_b.data_o), 32'(ed));
  endtask

  logic [3:0] seq_a5c3 [4] = '{4'h3, 4'hC, 4'h5, 4'hA};
  logic [3:0] seq_0f0f [4] = '{4'hF, 4'h0, 4'hF, 4'h0};
  logic       b2b_v    [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  logic [3:0] b2b_d    [10] = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h0, 4'hF, 4'hE, 4'hE, 4'hB, 4'h0};

  initial begin
    bus_a.valid_i = 1'b0; bus_a.data_i = '0; bus_a.ready_and_i = 1'b1;
    bus_b.valid_i = 1'b0; bus_b.data_i = '0; bus_b.ready_and_i = 1'b1;

    // Reset, then release
    repeat (3) step();
    check("rst_ready", 32'(bus_a.ready_and_o), 32'h0);
    check("rst_valid", 32'(bus_a.valid_o), 32'h0);
    check("rst_data", 32'(bus_a.data_o), 32'h0);
    reset_n_i = 1'b1;
    #2;
    check("rel_ready_first", 32'(bus_a.ready_and_o), 32'h0);
    step();
    check("rel_ready_second", 32'(bus_a.ready_and_o), 32'h1);
    check("rel_valid", 32'(bus_a.valid_o), 32'h0);

    // Full-rate drain of A5C3
    bus_a.valid_i = 1'b1; bus_a.data_i = 16'hA5C3; bus_a.ready_and_i = 1'b1;
    step();
    bus_a.valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_a("full", 1'b1, seq_a5c3[i]);
      step();
    end
    expect_a("full_gap", 1'b0, 4'h0);
    check("full_gap_ready", 32'(bus_a.ready_and_o), 32'h1);

    // Backpressure between words 1 and 2, junk valid_i during XMIT
    bus_a.valid_i = 1'b1; bus_a.data_i = 16'hA5C3;
    step();
    bus_a.valid_i = 1'b0;
    expect_a("bp_w0", 1'b1, 4'h3);
    step();
    expect_a("bp_w1", 1'b1, 4'hC);
    bus_a.ready_and_i = 1'b0; bus_a.valid_i = 1'b1; bus_a.data_i = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_a("bp_stall", 1'b1, 4'hC);
    end
    bus_a.ready_and_i = 1'b1; bus_a.valid_i = 1'b0;
    step();
    expect_a("bp_w2", 1'b1, 4'h5);
    step();
    expect_a("bp_w3", 1'b1, 4'hA);
    step();
    expect_a("bp_gap", 1'b0, 4'h0);
    step();
    expect_a("bp_no_capture", 1'b0, 4'h0);

    // Back-to-back 1234 then BEEF with valid_i held high
    bus_a.valid_i = 1'b1; bus_a.data_i = 16'h1234;
    step();
    bus_a.data_i = 16'hBEEF;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) bus_a.valid_i = 1'b0;
      expect_a("b2b", b2b_v[i], b2b_d[i]);
      step();
    end

    // Reset mid-transmit, then a clean word
    bus_a.valid_i = 1'b1; bus_a.data_i = 16'hA5C3;
    step();
    bus_a.valid_i = 1'b0;
    expect_a("ab_w0", 1'b1, 4'h3);
    step();
    expect_a("ab_w1", 1'b1, 4'hC);
    step();
    expect_a("ab_w2", 1'b1, 4'h5);
    reset_n_i = 1'b0;
    #2;
    check("ab_async_valid", 32'(bus_a.valid_o), 32'h0);
    check("ab_async_ready", 32'(bus_a.ready_and_o), 32'h0);
    check("ab_async_data", 32'(bus_a.data_o), 32'h0);
    step();
    step();
    reset_n_i = 1'b1;
    check("ab_init_ready", 32'(bus_a.ready_and_o), 32'h0);
    step();
    check("ab_idle_ready", 32'(bus_a.ready_and_o), 32'h1);
    bus_a.valid_i = 1'b1; bus_a.data_i = 16'h0F0F;
    step();
    bus_a.valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_a("rec", 1'b1, seq_0f0f[i]);
      step();
    end
    expect_a("rec_gap", 1'b0, 4'h0);

    // Single-word instance: one accept every two cycles
    bus_b.valid_i = 1'b1; bus_b.data_i = 8'h5A; bus_b.ready_and_i = 1'b1;
    step();
    expect_b("one_w0", 1'b1, 8'h5A);
    bus_b.data_i = 8'hC3;
    step();
    expect_b("one_gap0", 1'b0, 8'h00);
    check("one_gap0_ready", 32'(bus_b.ready_and_o), 32'h1);
    step();
    expect_b("one_w1", 1'b1, 8'hC3);
    bus_b.valid_i = 1'b0;
    step();
    expect_b("one_gap1", 1'b0, 8'h00);

    // Randomized traffic on both instances with occasional reset pulses
    for (int c = 0; c < 600; c++) begin
      bus_a.valid_i     = ($urandom_range(0, 1) == 1);
      bus_a.data_i      = 16'($urandom);
      bus_a.ready_and_i = ($urandom_range(0, 3) != 0);
      bus_b.valid_i     = ($urandom_range(0, 1) == 1);
      bus_b.data_i      = 8'($urandom);
      bus_b.ready_and_i = ($urandom_range(0, 2) != 0);
      reset_n_i         = ($urandom_range(0, 149) != 0);
      step();
    end
    reset_n_i = 1'b1;
    repeat (3) step();

    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bsg_parallel_in_serial_out_arst.md
Name: bsg_parallel_in_serial_out_arst

Overview:
Transmit-side width converter. Accepts one wide word of els_p*width_p bits over a ready/valid input and emits it as els_p narrow words of width_p bits over a ready/valid output, least-significant word first. It sits at the sending end of a narrow datapath, feeding a matching serial-in/parallel-out collector or a narrow link.
- Single clock.
- Asynchronous active-low reset.

Parameters:
- width_p, 4, bits per output (serial) word; must be at least 1.
- els_p, 4, number of output words per input word; must be at least 1.
- lg_els_lp, derived as max(1, clog2(els_p)), width of the word index; not user-set.

Ports:
- clk_i  input  1  sole clock; all state updates on the rising edge.
- reset_n_i  input  1  reset, asynchronous and active-low.
- valid_i  input  1  upstream word valid.
- data_i  input  els_p*width_p  upstream wide word; word k is data_i[k*width_p +: width_p].
- ready_and_o  output  1  block can accept a wide word this cycle.
- valid_o  output  1  data_o holds a valid narrow word.
- data_o  output  width_p  current narrow word.
- ready_and_i  input  1  downstream accepts data_o this cycle.

Behaviour:
- States: INIT, IDLE, XMIT; the state register is async-reset to INIT.
- Reset values while reset_n_i is low:
  - state = INIT, word index = 0, data register = 0.
  - ready_and_o = 0, valid_o = 0, data_o = 0.
- All outputs derive from registered state only; there is no combinational path from any input to any output.
- INIT:
  - ready_and_o = 0, valid_o = 0.
  - Moves to IDLE on the first rising edge after reset_n_i deasserts, unconditionally.
- IDLE:
  - ready_and_o = 1, valid_o = 0.
  - On valid_i & ready_and_o: capture data_i into the data register, set index = 0, go to XMIT.
  - Otherwise hold.
- XMIT:
  - ready_and_o = 0, valid_o = 1, data_o = data register word[index].
  - On ready_and_i with index < els_p-1: index increments by 1.
  - On ready_and_i with index == els_p-1: go to IDLE and clear index to 0. The data register is left unchanged, and data_o is don't-care while valid_o = 0.
  - Without ready_and_i: index and data hold, so data_o is stable while valid_o = 1 and not yet accepted.
  - valid_i and data_i are ignored throughout XMIT.
- Latency and throughput:
  - Input accepted at edge N gives valid_o = 1 with word 0 in the cycle after edge N.
  - Full-rate drain (ready_and_i held high) presents els_p consecutive words, then one IDLE cycle before the next accept.
  - Sustained throughput is one wide word per els_p+1 cycles.
- els_p == 1:
  - The index stays 0.
  - Each accept yields exactly one output word, then a return to IDLE.
- Reset asserted mid-XMIT:
  - State is immediately INIT and valid_o drops without waiting for a clock edge.
  - The partially sent word is discarded and not resumed.
- Index width rules:
  - The index never exceeds els_p-1.
  - No wrap beyond els_p-1 is legal; an assertion flags index >= els_p.
- ready_and_i while valid_o = 0 has no effect.

Decomposition:
- Shared package bsg_piso_pkg:
  - State enum bsg_piso_state_e {INIT, IDLE, XMIT}, 2-bit encoding.
  - No other constants.
- One sub-module, bsg_piso_index_counter:
  - Up-counter with clear and enable, async active-low reset.
  - Parameters: max_val_p = els_p-1.
- The top level holds the FSM, the data register and the word-select mux.

Test Plan (width_p=4, els_p=4 unless noted):
- Reset then release:
  - ready_and_o = 0 during reset and during the first cycle after release.
  - ready_and_o = 1 from the second edge onward; valid_o = 0 throughout.
- Accept data_i = 16'hA5C3 with ready_and_i tied high:
  - data_o = 4'h3, 4'hC, 4'h5, 4'hA on four consecutive valid cycles, then valid_o = 0 for exactly one cycle.
  - ready_and_o = 1 again in that cycle.
- Same word with backpressure, ready_and_i low for 3 cycles between words 1 and 2:
  - data_o holds 4'hC with valid_o = 1 for all stalled cycles.
  - Order is preserved.
  - valid_i toggled with data 16'hFFFF during XMIT is not captured.
- Back-to-back input words 16'h1234 and 16'hBEEF with valid_i always high:
  - Output sequence is 4,3,2,1, one idle cycle, then F,E,E,B.
  - The second word is accepted on the IDLE cycle.
- reset_n_i pulsed low after word 1 of 16'hA5C3:
  - valid_o drops asynchronously.
  - After recovery, a new word 16'h0F0F yields F,0,F,0 with no residue from the aborted word.
- els_p=1, width_p=8:
  - Inputs 8'h5A and 8'hC3 each yield a single output word, accepted every 2 cycles under full-rate handshakes.
